mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter: NTERMS, default 8, number of products summed per accumulation run (legal 1..15).
REQ-002 Parameter: ACC_W, default 12, accumulator width in bits (legal 8..16).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin a new accumulation run.
REQ-006 Port: pro  input  8  unsigned product from the upstream 4x4 multiplier.
REQ-007 Port: in_valid  input  1  pro is valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts pro this cycle.
REQ-009 Port: acc  output  ACC_W  running/final unsigned sum.
REQ-010 Port: out_valid  output  1  acc holds the final sum of a completed run.
REQ-011 Port: out_ready  input  1  downstream accepts the result.
REQ-012 Port: ovf  output  1  sticky saturation flag for the current run.
REQ-013 Port: busy  output  1  high in ACCUM or DONE.
REQ-014 Port: cnt  output  4  number of products accepted in the current run.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-016 In IDLE, in_ready=0, out_valid=0, busy=0; acc, cnt and ovf SHALL hold their last values.
REQ-017 IDLE with start=1 SHALL clear acc, cnt and ovf to 0 and enter ACCUM on the next edge.
REQ-018 In ACCUM, in_ready SHALL be 1 combinationally; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-019 On each transfer, acc SHALL become acc + zero-extended pro, and cnt SHALL increment by 1.
REQ-020 If acc + pro exceeds 2^ACC_W - 1, acc SHALL saturate to 2^ACC_W - 1 and ovf SHALL be set to 1 for the rest of the run.
REQ-021 Cycles with in_valid=0 in ACCUM SHALL leave acc and cnt unchanged; gaps of any length are legal.
REQ-022 Throughput SHALL be one product per cycle; there SHALL be no bubbles between consecutive transfers.
REQ-023 The transfer that makes cnt equal NTERMS SHALL move the FSM to DONE on the same edge.
REQ-024 Result latency: out_valid SHALL be 1 in the first cycle after the last transfer.
REQ-025 In DONE, in_ready SHALL be 0 and acc, ovf and cnt SHALL be held stable while out_valid=1.
REQ-026 DONE with out_ready=1 SHALL complete the result handshake and enter IDLE on that edge.
REQ-027 A result SHALL NOT be dropped or duplicated; out_valid stays high until it is accepted.
REQ-028 start SHALL be ignored in ACCUM and DONE, including in the DONE handshake cycle.
REQ-029 busy SHALL equal 1 exactly when the state is ACCUM or DONE.
REQ-030 All outputs SHALL be registered or decoded solely from state; none depends combinationally on pro.

Reset
REQ-031 With rst=1 at a rising edge, state SHALL become IDLE, and acc, cnt, ovf, out_valid, in_ready and busy SHALL all be 0.
REQ-032 rst SHALL take priority over start, transfers and the result handshake.
REQ-033 Reset asserted mid-run (ACCUM or DONE) SHALL abandon the run with no result emitted.

Verification
REQ-034 Default parameters, start, then eight back-to-back transfers with pro=225, out_ready=1 -> out_valid one cycle after the 8th transfer; acc=1800, ovf=0, cnt=8.
REQ-035 ACC_W=10, same stimulus as REQ-034 -> acc=1023 and ovf=1, first set on the 5th transfer (5*225=1125 > 1023).
REQ-036 Products 1,2,3,4,5,6,7,8 with in_valid gaps of 0-3 cycles, then out_ready held low 5 cycles -> acc=36 held stable with out_valid=1 for all 5 cycles; return to IDLE on the cycle out_ready rises.
REQ-037 start pulsed during ACCUM (after 3 transfers) and during DONE -> acc and cnt are not cleared; no new run begins until the FSM is back in IDLE.
REQ-038 rst asserted after 4 of 8 transfers -> next cycle shows state IDLE, acc=0, cnt=0, out_valid=0; a fresh run with eight products of 10 gives acc=80.
REQ-039 NTERMS=1, start then one transfer with pro=0 -> out_valid next cycle, acc=0, ovf=0, cnt=1.

Source files
------------

// File: rtl/mac_accumulator_if.sv
// Handshake bundle between a product source, the MAC accumulator and its result sink.
// The master side drives start/pro/in_valid/out_ready; the slave is the accumulator.
interface mac_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             start;
    logic [7:0]       pro;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic             busy;
    logic [3:0]       cnt;

    modport master (
        output start, pro, in_valid, out_ready,
        input  in_ready, acc, out_valid, ovf, busy, cnt
    );

    modport slave (
        input  start, pro, in_valid, out_ready,
        output in_ready, acc, out_valid, ovf, busy, cnt
    );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating accumulator that sums NTERMS unsigned 8-bit products per run
// and presents the total through a valid/ready result handshake.
module mac_accumulator #(
    parameter int NTERMS = 8,
    parameter int ACC_W  = 12
) (
    input logic              clk,
    input logic              rst,
    mac_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [3:0]       LAST_CNT = 4'(NTERMS - 1);
    localparam logic [ACC_W-1:0] SAT_VAL  = '1;

    state_t           state;
    logic [ACC_W-1:0] acc_q;
    logic [3:0]       cnt_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [ACC_W:0]   sum;
    logic             xfer;

    // The extra top bit of sum is the carry that signals saturation.
    always_comb begin
        sum  = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.pro};
        xfer = in_ready_q & bus.in_valid;
    end

    // Handshake flags are registered alongside the state so they mirror it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACCUM;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (sum[ACC_W]) begin
                            acc_q <= SAT_VAL;
                            ovf_q <= 1'b1;
                        end else begin
                            acc_q <= sum[ACC_W-1:0];
                        end
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LAST_CNT) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.acc       = acc_q;
    assign bus.cnt       = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator: default, narrow-accumulator
// and single-term instances share one clock and reset.
module tb_mac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.ACC_W(12)) b0 ();
    mac_accumulator_if #(.ACC_W(10)) b1 ();
    mac_accumulator_if #(.ACC_W(12)) b2 ();

    mac_accumulator #(.NTERMS(8), .ACC_W(12)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mac_accumulator #(.NTERMS(8), .ACC_W(10)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mac_accumulator #(.NTERMS(1), .ACC_W(12)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (b0.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0d want 0", b0.busy); end
        n_cmp++;
        if (b0.acc !== 12'd0) begin n_err++; $display("[TB] FAIL reset_acc: got %0d want 0", b0.acc); end
        n_cmp++;
        if (b0.cnt !== 4'd0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d want 0", b0.cnt); end
        n_cmp++;
        if ({b0.ovf, b0.out_valid, b0.in_ready} !== 3'b000) begin
            n_err++; $display("[TB] FAIL reset_flags: got ovf/ov/ir=%b want 000", {b0.ovf, b0.out_valid, b0.in_ready});
        end
    endtask

    task automatic test_full_rate();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        n_cmp++;
        if ({b0.busy, b0.in_ready} !== 2'b11) begin
            n_err++; $display("[TB] FAIL accum_entry: got busy/ir=%b want 11", {b0.busy, b0.in_ready});
        end
        for (int i = 0; i < 8; i++) begin
            b0.pro = 8'd225;
            b0.in_valid = 1'b1;
            tick();
            n_cmp++;
            if (b0.cnt !== 4'(i + 1)) begin n_err++; $display("[TB] FAIL b2b_cnt%0d: got %0d want %0d", i, b0.cnt, i + 1); end
        end
        b0.in_valid = 1'b0;
        n_cmp++;
        if (b0.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL full_out_valid: got %0d want 1", b0.out_valid); end
        n_cmp++;
        if (b0.acc !== 12'd1800) begin n_err++; $display("[TB] FAIL full_acc: got %0d want 1800", b0.acc); end
        n_cmp++;
        if ({b0.ovf, b0.in_ready} !== 2'b00) begin
            n_err++; $display("[TB] FAIL full_ovf_ir: got %b want 00", {b0.ovf, b0.in_ready});
        end
        b0.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0;
        n_cmp++;
        if ({b0.busy, b0.out_valid} !== 2'b00) begin
            n_err++; $display("[TB] FAIL full_accept: got busy/ov=%b want 00", {b0.busy, b0.out_valid});
        end
        n_cmp++;
        if (b0.acc !== 12'd1800 || b0.cnt !== 4'd8) begin
            n_err++; $display("[TB] FAIL idle_hold: got acc=%0d cnt=%0d want 1800/8", b0.acc, b0.cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_acc;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            b1.pro = 8'd225;
            b1.in_valid = 1'b1;
            tick();
            exp_acc = (225 * k > 1023) ? 1023 : 225 * k;
            n_cmp++;
            if (b1.acc !== 10'(exp_acc) || b1.ovf !== (k >= 5)) begin
                n_err++; $display("[TB] FAIL sat_step%0d: got acc=%0d ovf=%0d want %0d/%0d", k, b1.acc, b1.ovf, exp_acc, k >= 5);
            end
        end
        b1.in_valid = 1'b0;
        n_cmp++;
        if (b1.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL sat_out_valid: got %0d want 1", b1.out_valid); end
        b1.out_ready = 1'b1;
        tick();
        b1.out_ready = 1'b0;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        n_cmp++;
        if (b1.ovf !== 1'b0 || b1.acc !== 10'd0 || b1.busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL sat_restart: got ovf=%0d acc=%0d busy=%0d want 0/0/1", b1.ovf, b1.acc, b1.busy);
        end
    endtask

    task automatic test_gaps();
        int running;
        running = 0;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            b0.in_valid = 1'b0;
            b0.pro = 8'd99;
            repeat ((i - 1) % 4) tick();
            n_cmp++;
            if (b0.acc !== 12'(running) || b0.cnt !== 4'(i - 1)) begin
                n_err++; $display("[TB] FAIL gap_hold%0d: got acc=%0d cnt=%0d want %0d/%0d", i, b0.acc, b0.cnt, running, i - 1);
            end
            b0.pro = 8'(i);
            b0.in_valid = 1'b1;
            tick();
            running += i;
        end
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (b0.out_valid !== 1'b1 || b0.acc !== 12'd36 || b0.cnt !== 4'd8) begin
                n_err++; $display("[TB] FAIL stall%0d: got ov=%0d acc=%0d cnt=%0d want 1/36/8", c, b0.out_valid, b0.acc, b0.cnt);
            end
            tick();
        end
        b0.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0;
        n_cmp++;
        if ({b0.busy, b0.out_valid} !== 2'b00) begin
            n_err++; $display("[TB] FAIL stall_release: got busy/ov=%b want 00", {b0.busy, b0.out_valid});
        end
    endtask

    task automatic test_start_ignored();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.pro = 8'd10;
        b0.in_valid = 1'b1;
        repeat (3) tick();
        b0.in_valid = 1'b0;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        n_cmp++;
        if (b0.acc !== 12'd30 || b0.cnt !== 4'd3 || b0.busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL start_in_accum: got acc=%0d cnt=%0d busy=%0d want 30/3/1", b0.acc, b0.cnt, b0.busy);
        end
        b0.in_valid = 1'b1;
        repeat (5) tick();
        b0.in_valid = 1'b0;
        b0.start = 1'b1;
        tick();
        n_cmp++;
        if (b0.out_valid !== 1'b1 || b0.acc !== 12'd80 || b0.cnt !== 4'd8) begin
            n_err++; $display("[TB] FAIL start_in_done: got ov=%0d acc=%0d cnt=%0d want 1/80/8", b0.out_valid, b0.acc, b0.cnt);
        end
        b0.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0;
        b0.start = 1'b0;
        n_cmp++;
        if (b0.busy !== 1'b0 || b0.acc !== 12'd80 || b0.cnt !== 4'd8) begin
            n_err++; $display("[TB] FAIL start_in_handshake: got busy=%0d acc=%0d cnt=%0d want 0/80/8", b0.busy, b0.acc, b0.cnt);
        end
    endtask

    task automatic test_reset_midrun();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.pro = 8'd20;
        b0.in_valid = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.in_valid = 1'b0;
        n_cmp++;
        if (b0.busy !== 1'b0 || b0.acc !== 12'd0 || b0.cnt !== 4'd0 || b0.out_valid !== 1'b0) begin
            n_err++; $display("[TB] FAIL midrun_reset: got busy=%0d acc=%0d cnt=%0d ov=%0d want 0/0/0/0", b0.busy, b0.acc, b0.cnt, b0.out_valid);
        end
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.pro = 8'd10;
        b0.in_valid = 1'b1;
        repeat (8) tick();
        b0.in_valid = 1'b0;
        n_cmp++;
        if (b0.out_valid !== 1'b1 || b0.acc !== 12'd80) begin
            n_err++; $display("[TB] FAIL fresh_run: got ov=%0d acc=%0d want 1/80", b0.out_valid, b0.acc);
        end
        b0.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.out_ready = 1'b0;
        n_cmp++;
        if (b0.out_valid !== 1'b0 || b0.acc !== 12'd0) begin
            n_err++; $display("[TB] FAIL reset_in_done: got ov=%0d acc=%0d want 0/0", b0.out_valid, b0.acc);
        end
    endtask

    task automatic test_single_term();
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        b2.pro = 8'd0;
        b2.in_valid = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        n_cmp++;
        if (b2.out_valid !== 1'b1 || b2.acc !== 12'd0 || b2.ovf !== 1'b0 || b2.cnt !== 4'd1) begin
            n_err++; $display("[TB] FAIL single_term: got ov=%0d acc=%0d ovf=%0d cnt=%0d want 1/0/0/1", b2.out_valid, b2.acc, b2.ovf, b2.cnt);
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
        n_cmp++;
        if (b2.busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_accept: got busy=%0d want 0", b2.busy); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        b0.start = 1'b0; b0.pro = 8'd0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
        b1.start = 1'b0; b1.pro = 8'd0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        b2.start = 1'b0; b2.pro = 8'd0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
        test_reset();
        test_full_rate();
        test_saturation();
        test_gaps();
        test_start_ignored();
        test_reset_midrun();
        test_single_term();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
